// File: rtl/uart_game_pkg.sv
// Shared definitions for the game-link frame encoder and decoder.
// Holds the frame FSM states, the default SYNC byte and the checksum helpers.
package uart_game_pkg;

  localparam int         MAX_N_BYTES  = 32;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_ID      = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5
  } frame_state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // The transmitted byte makes the sum of all non-SYNC bytes come out to zero.
  function automatic logic [7:0] csum_final(input logic [7:0] acc);
    return 8'h00 - acc;
  endfunction

endpackage

// File: rtl/uart_game_frame_tx_timer.sv
// Periodic refresh tick for the frame transmitter (module uart_frame_timer).
// REFRESH_CYCLES = 0 disables the timer entirely; tick is then tied low.
module uart_frame_timer #(
  parameter int REFRESH_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  generate
    if (REFRESH_CYCLES > 0) begin : g_timer
      localparam int            TW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [TW-1:0] LAST = TW'(REFRESH_CYCLES - 1);

      logic [TW-1:0] timer_q;
      logic [TW-1:0] timer_d;

      always_comb begin
        if (timer_q == LAST) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1'b1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          timer_q <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end

      assign tick = (timer_q == LAST);
    end else begin : g_no_timer
      logic unused_s;
      assign unused_s = clk ^ rst;
      assign tick     = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/uart_game_frame_tx.sv
// Framed game-state transmitter: SYNC, ID, [SEQ], payload, CHECKSUM into the UART TX FIFO.
// Define UART_FRAME_SEQ_EN to insert an 8-bit per-frame sequence byte after ID.
module uart_game_frame_tx
  import uart_game_pkg::*;
#(
  parameter int         N_BYTES        = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter logic [7:0] NODE_ID        = 8'h01,
  parameter int         REFRESH_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_BYTES*8-1:0] payload,
  input  logic                 tx_full,
  output logic [7:0]           uart_data,
  output logic                 uart_wr,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt
);

  localparam int               IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  frame_state_t         state_q, state_d, eff_state_s;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_BYTES*8-1:0] shadow_q, shadow_d;
  logic [7:0]           csum_q, csum_d;
  logic                 pending_q, pending_d;
  logic [7:0]           uart_data_q, uart_data_d;
  logic                 uart_wr_q, uart_wr_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [7:0]           payload_byte_s;
  logic                 tick_s, trigger_s;
`ifdef UART_FRAME_SEQ_EN
  logic [7:0]           seq_q, seq_d;
`endif

  uart_frame_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign trigger_s = start | tick_s;

  // Outputs are registered, so each cycle decides the byte that appears on the FIFO port next cycle.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    csum_d         = csum_q;
    pending_d      = pending_q;
    uart_data_d    = uart_data_q;
    uart_wr_d      = 1'b0;
    busy_d         = busy_q;
    frame_done_d   = 1'b0;
    frame_cnt_d    = frame_cnt_q;
`ifdef UART_FRAME_SEQ_EN
    seq_d          = seq_q;
`endif
    eff_state_s    = state_q;
    payload_byte_s = shadow_q[{idx_q, 3'b000} +: 8];

    if (state_q == ST_IDLE) begin
      if (trigger_s) begin
        eff_state_s = ST_SYNC;
        shadow_d    = payload;
        csum_d      = 8'h00;
        idx_d       = '0;
        busy_d      = 1'b1;
      end else begin
        busy_d      = 1'b0;
      end
    end else begin
      if (trigger_s) begin
        pending_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
    end

    if ((eff_state_s != ST_IDLE) && !tx_full) begin
      uart_wr_d = 1'b1;
      case (eff_state_s)
        ST_SYNC: begin
          uart_data_d = SYNC_BYTE;
          state_d     = ST_ID;
        end
        ST_ID: begin
          uart_data_d = NODE_ID;
          csum_d      = csum_add(csum_q, NODE_ID);
`ifdef UART_FRAME_SEQ_EN
          state_d     = ST_SEQ;
`else
          state_d     = ST_PAYLOAD;
`endif
        end
`ifdef UART_FRAME_SEQ_EN
        ST_SEQ: begin
          uart_data_d = seq_q;
          csum_d      = csum_add(csum_q, seq_q);
          state_d     = ST_PAYLOAD;
        end
`endif
        ST_PAYLOAD: begin
          uart_data_d = payload_byte_s;
          csum_d      = csum_add(csum_q, payload_byte_s);
          if (idx_q == LAST_IDX) begin
            state_d = ST_CSUM;
          end else begin
            idx_d   = idx_q + IDX_W'(1'b1);
            state_d = ST_PAYLOAD;
          end
        end
        ST_CSUM: begin
          uart_data_d  = csum_final(csum_q);
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
`ifdef UART_FRAME_SEQ_EN
          seq_d        = seq_q + 8'd1;
`endif
          // A queued request chains directly into the next SYNC with no idle gap.
          if (pending_q || trigger_s) begin
            state_d   = ST_SYNC;
            pending_d = 1'b0;
            shadow_d  = payload;
            csum_d    = 8'h00;
            idx_d     = '0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        default: begin
          uart_wr_d = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end else begin
      state_d = eff_state_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      csum_q       <= 8'h00;
      pending_q    <= 1'b0;
      uart_data_q  <= 8'h00;
      uart_wr_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
`ifdef UART_FRAME_SEQ_EN
      seq_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      csum_q       <= csum_d;
      pending_q    <= pending_d;
      uart_data_q  <= uart_data_d;
      uart_wr_q    <= uart_wr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef UART_FRAME_SEQ_EN
      seq_q        <= seq_d;
`endif
    end
  end

  assign uart_data  = uart_data_q;
  assign uart_wr    = uart_wr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_uart_game_frame_tx.sv
// Scoreboard bench for uart_game_frame_tx: expected bytes are queued at stimulus time
// and popped by per-instance monitors on every FIFO write strobe.
module tb_uart_game_frame_tx;

`ifdef UART_FRAME_SEQ_EN
  localparam int FRAME_LEN = 8;
  logic [9:0] hand_v [8] = '{10'h2A5, 10'h001, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h1F5};
`else
  localparam int FRAME_LEN = 7;
  logic [9:0] hand_v [7] = '{10'h2A5, 10'h001, 10'h001, 10'h002, 10'h003, 10'h004, 10'h1F5};
`endif

  logic        clk;
  logic        rst, start, tx_full;
  logic [31:0] payload;
  logic [7:0]  uart_data;
  logic        uart_wr, busy, frame_done;
  logic [15:0] frame_cnt;

  logic        rst_t, start_t, tx_full_t;
  logic [31:0] payload_t;
  logic [7:0]  uart_data_t;
  logic        uart_wr_t, busy_t, frame_done_t;
  logic [15:0] frame_cnt_t;

  int tests, fails;
  int exp_cnt;
  logic [7:0] seq_m;
  logic [9:0] exp_q [$];
  logic [9:0] exp_t_q [$];
  logic [9:0] mon_e, mon_t_e;
  logic [7:0] mon_sum, mon_t_sum;

  uart_game_frame_tx #(.N_BYTES(4), .NODE_ID(8'h01), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .start(start), .payload(payload), .tx_full(tx_full),
    .uart_data(uart_data), .uart_wr(uart_wr), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  uart_game_frame_tx #(.N_BYTES(4), .NODE_ID(8'h01), .REFRESH_CYCLES(100)) dut_t (
    .clk(clk), .rst(rst_t), .start(start_t), .payload(payload_t), .tx_full(tx_full_t),
    .uart_data(uart_data_t), .uart_wr(uart_wr_t), .busy(busy_t), .frame_done(frame_done_t),
    .frame_cnt(frame_cnt_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int which, input logic [9:0] e);
    if (which == 0) exp_q.push_back(e);
    else exp_t_q.push_back(e);
  endtask

  // Entry layout: {is_sync, is_last, data}.
  task automatic push_frame(input int which, input logic [31:0] pl, input logic [7:0] seq);
    logic [7:0] s;
    s = 8'h01;
    push_byte(which, 10'h2A5);
    push_byte(which, 10'h001);
`ifdef UART_FRAME_SEQ_EN
    push_byte(which, {2'b00, seq});
    s = s + seq;
`else
    s = s + (seq & 8'h00);
`endif
    for (int k = 0; k < 4; k++) begin
      push_byte(which, {2'b00, pl[8*k +: 8]});
      s = s + pl[8*k +: 8];
    end
    push_byte(which, {2'b01, 8'h00 - s});
  endtask

  // Monitor for the start-driven instance.
  always @(negedge clk) begin
    if (uart_wr) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got %0h expected no write", uart_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte", {23'd0, frame_done, uart_data}, {23'd0, mon_e[8:0]});
        if (mon_e[9]) mon_sum = 8'h00;
        else mon_sum = mon_sum + uart_data;
        if (mon_e[8]) check("frame_sum_zero", {24'd0, mon_sum}, 32'd0);
      end
    end
    if (frame_done) check("done_with_wr", {31'd0, uart_wr}, 32'd1);
  end

  // Monitor for the refresh-timer instance.
  always @(negedge clk) begin
    if (uart_wr_t) begin
      if (exp_t_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write_t: got %0h expected no write", uart_data_t);
      end else begin
        mon_t_e = exp_t_q.pop_front();
        check("byte_t", {23'd0, frame_done_t, uart_data_t}, {23'd0, mon_t_e[8:0]});
        if (mon_t_e[9]) mon_t_sum = 8'h00;
        else mon_t_sum = mon_t_sum + uart_data_t;
        if (mon_t_e[8]) check("frame_sum_zero_t", {24'd0, mon_t_sum}, 32'd0);
      end
    end
  end

  task automatic send_frame(input logic [31:0] pl, input int stall_at, input int stall_len,
                            input int extra_at, input bit hand);
    int n;
    bit prev_full;
    if (hand) begin
      foreach (hand_v[i]) push_byte(0, hand_v[i]);
    end else begin
      push_frame(0, pl, seq_m);
    end
    payload = pl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    payload = 32'hFFFFFFFF;
    check("sync_latency", {23'd0, uart_wr, uart_data}, {23'd0, 1'b1, 8'hA5});
    check("busy_start", {31'd0, busy}, 32'd1);
    n = 1;
    while (!frame_done && n < 200) begin
      if (n == stall_at) tx_full = 1'b1;
      else if (n == stall_at + stall_len) tx_full = 1'b0;
      if (extra_at != 0 && (n == extra_at || n == extra_at + 2)) start = 1'b1;
      else start = 1'b0;
      if (extra_at != 0 && n == extra_at) push_frame(0, 32'hFFFFFFFF, seq_m + 8'd1);
      prev_full = tx_full;
      @(posedge clk); #1;
      n++;
      if (prev_full) begin
        check("stall_no_wr", {31'd0, uart_wr}, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    tx_full = 1'b0;
    exp_cnt++;
    seq_m = seq_m + 8'd1;
    check("frame_len", n, FRAME_LEN + stall_len);
    check("frame_cnt", {16'd0, frame_cnt}, exp_cnt);
    check("busy_at_done", {31'd0, busy}, 32'd1);
    if (extra_at != 0) begin
      @(posedge clk); #1;
      check("chain_sync", {23'd0, uart_wr, uart_data}, {23'd0, 1'b1, 8'hA5});
      check("chain_busy", {31'd0, busy}, 32'd1);
      n = 1;
      while (!frame_done && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      exp_cnt++;
      seq_m = seq_m + 8'd1;
      check("chain_len", n, FRAME_LEN);
      check("chain_frame_cnt", {16'd0, frame_cnt}, exp_cnt);
    end
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_wr", {31'd0, uart_wr}, 32'd0);
  endtask

  initial begin
    int n, k;
    int starts [3];
    tests = 0; fails = 0; exp_cnt = 0; seq_m = 8'h00;
    mon_sum = 8'h00; mon_t_sum = 8'h00;
    rst = 1'b1; start = 1'b0; tx_full = 1'b0; payload = 32'h0;
    rst_t = 1'b1; start_t = 1'b0; tx_full_t = 1'b0; payload_t = 32'h04030201;
    starts = '{0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, uart_data}, 32'd0);
    check("rst_wr", {31'd0, uart_wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send_frame(32'h04030201, 0, 0, 0, 1'b1);
    send_frame(32'h04030201, 4, 3, 0, 1'b0);
    send_frame(32'h11223344, 0, 0, 2, 1'b0);
`ifdef UART_FRAME_SEQ_EN
    while (exp_cnt < 257) send_frame(32'h80FF7F01 + exp_cnt, 0, 0, 0, 1'b0);
    check("seq_wrapped", {24'd0, seq_m}, 32'd1);
`endif
    check("main_queue_empty", exp_q.size(), 32'd0);

    push_frame(1, 32'h04030201, 8'h00);
    push_frame(1, 32'h04030201, 8'h01);
    push_byte(1, 10'h2A5);
    push_byte(1, 10'h001);
    rst_t = 1'b0;
    n = 0; k = 0;
    while (n < 301) begin
      @(posedge clk); #1;
      n++;
      if (uart_wr_t && uart_data_t == 8'hA5 && k < 3) begin
        starts[k] = n;
        k++;
      end
    end
    check("timer_start0", starts[0], 32'd100);
    check("timer_start1", starts[1], 32'd200);
    check("timer_start2", starts[2], 32'd300);
    check("timer_id_before_rst", {23'd0, uart_wr_t, uart_data_t}, {23'd0, 1'b1, 8'h01});
    rst_t = 1'b1;
    @(posedge clk); #1;
    check("abort_wr", {31'd0, uart_wr_t}, 32'd0);
    check("abort_data", {24'd0, uart_data_t}, 32'd0);
    check("abort_busy", {31'd0, busy_t}, 32'd0);
    check("abort_done", {31'd0, frame_done_t}, 32'd0);
    check("abort_cnt", {16'd0, frame_cnt_t}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("timer_queue_empty", exp_t_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
